// File: rtl/uart_frame_tx.sv
// Transmit side of the 4-byte UART frame link. It serialises one 32-bit word as four
// back-to-back characters, byte 0 first, each sent LSB-first with optional parity.
module uart_frame_tx #(
    parameter int BAUD_DIV  = 5208,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        parity_en,
    input  logic        parity_kind,
    input  logic        start,
    input  logic [31:0] data_in,
    output logic        txd,
    output logic        busy,
    output logic        byte_done,
    output logic        done
);

    // Any STOP_BITS value other than 2 gives one stop bit.
    localparam int STOPS = (STOP_BITS == 2) ? 2 : 1;
    localparam int TW    = $clog2(BAUD_DIV);
    localparam logic [TW-1:0] TMAX = TW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [1:0]  byte_idx, byte_idx_n;
    logic        stop_idx, stop_idx_n;
    logic [31:0] word, word_n;
    logic        par_en, par_en_n;
    logic        par_kind, par_kind_n;
    logic        txd_n, busy_n, byte_done_n, done_n;

    logic [7:0]  cur_byte;
    logic [2:0]  nxt_idx;
    logic        parity_bit;
    logic        tick;

    always_comb begin
        cur_byte   = word[{byte_idx, 3'b000} +: 8];
        nxt_idx    = bit_idx + 3'd1;
        parity_bit = par_kind ? ~^cur_byte : ^cur_byte;
        tick       = (timer == TMAX);

        state_n     = state;
        timer_n     = timer + 1'b1;
        bit_idx_n   = bit_idx;
        byte_idx_n  = byte_idx;
        stop_idx_n  = stop_idx;
        word_n      = word;
        par_en_n    = par_en;
        par_kind_n  = par_kind;
        txd_n       = txd;
        busy_n      = busy;
        byte_done_n = 1'b0;
        done_n      = 1'b0;

        // Each branch loads txd with the value of the bit that starts on the same edge.
        case (state)
            IDLE: begin
                timer_n = '0;
                txd_n   = 1'b1;
                if (start) begin
                    word_n     = data_in;
                    par_en_n   = parity_en;
                    par_kind_n = parity_kind;
                    byte_idx_n = 2'd0;
                    state_n    = START;
                    busy_n     = 1'b1;
                    txd_n      = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    timer_n   = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                    txd_n     = cur_byte[0];
                end
            end
            DATA: begin
                if (tick) begin
                    timer_n = '0;
                    if (bit_idx == 3'd7) begin
                        stop_idx_n = 1'b0;
                        if (par_en) begin
                            state_n = PARITY;
                            txd_n   = parity_bit;
                        end else begin
                            state_n = STOP;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        bit_idx_n = nxt_idx;
                        txd_n     = cur_byte[nxt_idx];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    timer_n    = '0;
                    stop_idx_n = 1'b0;
                    state_n    = STOP;
                    txd_n      = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    timer_n = '0;
                    if (stop_idx == 1'(STOPS - 1)) begin
                        byte_done_n = 1'b1;
                        if (byte_idx == 2'd3) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            txd_n   = 1'b1;
                        end else begin
                            byte_idx_n = byte_idx + 2'd1;
                            state_n    = START;
                            txd_n      = 1'b0;
                        end
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
                busy_n  = 1'b0;
                txd_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= 3'd0;
            byte_idx  <= 2'd0;
            stop_idx  <= 1'b0;
            word      <= '0;
            par_en    <= 1'b0;
            par_kind  <= 1'b0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            byte_done <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            bit_idx   <= bit_idx_n;
            byte_idx  <= byte_idx_n;
            stop_idx  <= stop_idx_n;
            word      <= word_n;
            par_en    <= par_en_n;
            par_kind  <= par_kind_n;
            txd       <= txd_n;
            busy      <= busy_n;
            byte_done <= byte_done_n;
            done      <= done_n;
        end
    end

endmodule
